// File: rtl/drive_nco_phase_bank.sv
// drive_nco_phase_bank: per-qubit NCO phase bank for the drive path.
// Each qubit has a frequency word (fcw), a z-step, a phase accumulator (acc)
// and a z-correction register (zcorr). The output stage emits the registered
// phase acc+zcorr of one selected qubit, one cycle after selection.
//
// Optional feature: define NCO_PHASE_DITHER_EN to add a 2-bit LFSR dither
// to phase_out. The default build has no dither.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   nco_phase_wr_en     per-qubit accumulate enable (acc += fcw)
//   nco_z_corr_wr_en    per-qubit z-correction enable
//   nco_z_corr_mode     per-qubit mode: 0 = accumulate z-step, 1 = hold
//   qubit_sel           qubit whose phase is emitted
//   cfg_wr_en/sel/addr/data  configuration write (sel 0 = fcw, 1 = z-step)
//   z_corr_clr          clear all z-correction registers
//   phase_out           registered phase of the selected qubit
//   phase_out_valid     selected qubit was accumulating that cycle
//   phase_out_qubit     qubit index tagged to phase_out
module drive_nco_phase_bank #(
  parameter int unsigned NUM_QUBIT_PER_BANK        = 16,
  parameter int unsigned QUBIT_ADDR_WIDTH_PER_BANK = 4,
  parameter int unsigned PHASE_WIDTH               = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_QUBIT_PER_BANK-1:0]        nco_phase_wr_en,
  input  logic [NUM_QUBIT_PER_BANK-1:0]        nco_z_corr_wr_en,
  input  logic [NUM_QUBIT_PER_BANK-1:0]        nco_z_corr_mode,
  input  logic [QUBIT_ADDR_WIDTH_PER_BANK-1:0] qubit_sel,
  input  logic                                 cfg_wr_en,
  input  logic                                 cfg_wr_sel,
  input  logic [QUBIT_ADDR_WIDTH_PER_BANK-1:0] cfg_wr_addr,
  input  logic [PHASE_WIDTH-1:0]               cfg_wr_data,
  input  logic                                 z_corr_clr,
  output logic [PHASE_WIDTH-1:0]               phase_out,
  output logic                                 phase_out_valid,
  output logic [QUBIT_ADDR_WIDTH_PER_BANK-1:0] phase_out_qubit
);

  localparam int unsigned NQ = NUM_QUBIT_PER_BANK;
  localparam int unsigned AW = QUBIT_ADDR_WIDTH_PER_BANK;
  localparam int unsigned PW = PHASE_WIDTH;

  logic [PW-1:0] fcw_q   [NQ];
  logic [PW-1:0] fcw_d   [NQ];
  logic [PW-1:0] zstep_q [NQ];
  logic [PW-1:0] zstep_d [NQ];
  logic [PW-1:0] acc_q   [NQ];
  logic [PW-1:0] acc_d   [NQ];
  logic [PW-1:0] zcorr_q [NQ];
  logic [PW-1:0] zcorr_d [NQ];

  logic [PW-1:0] phase_out_q,       phase_out_d;
  logic          phase_out_valid_q, phase_out_valid_d;
  logic [AW-1:0] phase_out_qubit_q, phase_out_qubit_d;

  logic sel_ok;
  logic cfg_addr_ok;

`ifdef NCO_PHASE_DITHER_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,14,13,11, free-running
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
`endif

  // Indices beyond the populated qubits act as no-ops
  always_comb begin
    sel_ok      = (32'(qubit_sel) < NQ);
    cfg_addr_ok = (32'(cfg_wr_addr) < NQ);
  end

  // Per-qubit state update; accumulations read the pre-write fcw/zstep
  always_comb begin
    fcw_d   = fcw_q;
    zstep_d = zstep_q;
    acc_d   = acc_q;
    zcorr_d = zcorr_q;
    for (int unsigned i = 0; i < NQ; i++) begin
      if (nco_phase_wr_en[i]) begin
        acc_d[i] = acc_q[i] + fcw_q[i];
      end
      if (z_corr_clr) begin
        zcorr_d[i] = '0;
      end else if (nco_z_corr_wr_en[i] && !nco_z_corr_mode[i]) begin
        zcorr_d[i] = zcorr_q[i] + zstep_q[i];
      end
    end
    if (cfg_wr_en && cfg_addr_ok) begin
      if (cfg_wr_sel) begin
        zstep_d[cfg_wr_addr] = cfg_wr_data;
      end else begin
        fcw_d[cfg_wr_addr] = cfg_wr_data;
      end
    end
  end

  // Output stage: pre-update phase of the selected qubit
  always_comb begin
    phase_out_d       = '0;
    phase_out_valid_d = 1'b0;
    phase_out_qubit_d = qubit_sel;
    if (sel_ok) begin
      phase_out_d       = acc_q[qubit_sel] + zcorr_q[qubit_sel];
      phase_out_valid_d = nco_phase_wr_en[qubit_sel];
    end
`ifdef NCO_PHASE_DITHER_EN
    phase_out_d = phase_out_d + PW'(lfsr_q[1:0]);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcw_q             <= '{default: '0};
      zstep_q           <= '{default: '0};
      acc_q             <= '{default: '0};
      zcorr_q           <= '{default: '0};
      phase_out_q       <= '0;
      phase_out_valid_q <= 1'b0;
      phase_out_qubit_q <= '0;
`ifdef NCO_PHASE_DITHER_EN
      lfsr_q            <= LFSR_SEED;
`endif
    end else begin
      fcw_q             <= fcw_d;
      zstep_q           <= zstep_d;
      acc_q             <= acc_d;
      zcorr_q           <= zcorr_d;
      phase_out_q       <= phase_out_d;
      phase_out_valid_q <= phase_out_valid_d;
      phase_out_qubit_q <= phase_out_qubit_d;
`ifdef NCO_PHASE_DITHER_EN
      lfsr_q            <= lfsr_d;
`endif
    end
  end

  assign phase_out       = phase_out_q;
  assign phase_out_valid = phase_out_valid_q;
  assign phase_out_qubit = phase_out_qubit_q;

endmodule

// File: tb/tb_drive_nco_phase_bank.sv
// Bench for drive_nco_phase_bank (default build, no dither): vector table plus
// hand sequences; expectations queued at drive time, compared one cycle later.
module tb_drive_nco_phase_bank;

  localparam int unsigned NQ = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned PW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [NQ-1:0] nco_phase_wr_en;
  logic [NQ-1:0] nco_z_corr_wr_en;
  logic [NQ-1:0] nco_z_corr_mode;
  logic [AW-1:0] qubit_sel;
  logic          cfg_wr_en;
  logic          cfg_wr_sel;
  logic [AW-1:0] cfg_wr_addr;
  logic [PW-1:0] cfg_wr_data;
  logic          z_corr_clr;
  logic [PW-1:0] phase_out;
  logic          phase_out_valid;
  logic [AW-1:0] phase_out_qubit;

  always #5 clk = ~clk;

  drive_nco_phase_bank #(
    .NUM_QUBIT_PER_BANK(NQ),
    .QUBIT_ADDR_WIDTH_PER_BANK(AW),
    .PHASE_WIDTH(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .nco_phase_wr_en(nco_phase_wr_en),
    .nco_z_corr_wr_en(nco_z_corr_wr_en),
    .nco_z_corr_mode(nco_z_corr_mode),
    .qubit_sel(qubit_sel),
    .cfg_wr_en(cfg_wr_en),
    .cfg_wr_sel(cfg_wr_sel),
    .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data),
    .z_corr_clr(z_corr_clr),
    .phase_out(phase_out),
    .phase_out_valid(phase_out_valid),
    .phase_out_qubit(phase_out_qubit)
  );

  typedef struct {
    logic [NQ-1:0] ph_en;
    logic [NQ-1:0] z_en;
    logic [NQ-1:0] z_mode;
    logic [AW-1:0] sel;
    logic          cfg_en;
    logic          cfg_sel;
    logic [AW-1:0] cfg_addr;
    logic [PW-1:0] cfg_data;
    logic          zclr;
    logic          rst;
    logic [PW-1:0] e_phase;
    logic          e_valid;
    logic [AW-1:0] e_qubit;
  } vec_t;

  typedef struct {
    int            id;
    logic [PW-1:0] phase;
    logic          valid;
    logic [AW-1:0] qubit;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(input logic [NQ-1:0] ph_en, input logic [NQ-1:0] z_en,
                              input logic [NQ-1:0] z_mode, input logic [AW-1:0] sel,
                              input logic cfg_en, input logic cfg_sel,
                              input logic [AW-1:0] cfg_addr, input logic [PW-1:0] cfg_data,
                              input logic zclr, input logic r,
                              input logic [PW-1:0] e_phase, input logic e_valid,
                              input logic [AW-1:0] e_qubit);
    vec_t v;
    v.ph_en = ph_en;     v.z_en = z_en;         v.z_mode = z_mode;
    v.sel = sel;         v.cfg_en = cfg_en;     v.cfg_sel = cfg_sel;
    v.cfg_addr = cfg_addr; v.cfg_data = cfg_data; v.zclr = zclr;
    v.rst = r;           v.e_phase = e_phase;   v.e_valid = e_valid;
    v.e_qubit = e_qubit;
    return v;
  endfunction

  // Compare the output registered at the last edge against the oldest expectation
  task automatic check_out();
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      tests++;
      if (phase_out !== e.phase || phase_out_valid !== e.valid || phase_out_qubit !== e.qubit) begin
        fails++;
        $display("FAIL vec%0d: got phase=%h valid=%b qubit=%0d, required phase=%h valid=%b qubit=%0d",
                 e.id, phase_out, phase_out_valid, phase_out_qubit, e.phase, e.valid, e.qubit);
      end
    end
  endtask

  task automatic apply(input vec_t v, input int id);
    exp_t e;
    @(negedge clk);
    check_out();
    nco_phase_wr_en  = v.ph_en;
    nco_z_corr_wr_en = v.z_en;
    nco_z_corr_mode  = v.z_mode;
    qubit_sel        = v.sel;
    cfg_wr_en        = v.cfg_en;
    cfg_wr_sel       = v.cfg_sel;
    cfg_wr_addr      = v.cfg_addr;
    cfg_wr_data      = v.cfg_data;
    z_corr_clr       = v.zclr;
    rst              = v.rst;
    e.id = id; e.phase = v.e_phase; e.valid = v.e_valid; e.qubit = v.e_qubit;
    sb.push_back(e);
  endtask

  initial begin
    int id;
    rst = 1'b1;
    nco_phase_wr_en = '0; nco_z_corr_wr_en = '0; nco_z_corr_mode = '0;
    qubit_sel = '0; cfg_wr_en = 1'b0; cfg_wr_sel = 1'b0; cfg_wr_addr = '0;
    cfg_wr_data = '0; z_corr_clr = 1'b0;

    //               ph_en     z_en  mode  sel cfg sel adr data      clr rst  phase    v  q
    // reset state
    tbl.push_back(mk(16'h0000, '0, '0, 4'd0, 0, 0, 4'd0, 16'h0000, 0, 1, 16'h0000, 0, 4'd0));
    // fcw[3]=0x0100, four accumulations observed on qubit 3
    tbl.push_back(mk(16'h0000, '0, '0, 4'd3, 1, 0, 4'd3, 16'h0100, 0, 0, 16'h0000, 0, 4'd3));
    tbl.push_back(mk(16'h0008, '0, '0, 4'd3, 0, 0, 4'd0, 16'h0000, 0, 0, 16'h0000, 1, 4'd3));
    tbl.push_back(mk(16'h0008, '0, '0, 4'd3, 0, 0, 4'd0, 16'h0000, 0, 0, 16'h0100, 1, 4'd3));
    tbl.push_back(mk(16'h0008, '0, '0, 4'd3, 0, 0, 4'd0, 16'h0000, 0, 0, 16'h0200, 1, 4'd3));
    tbl.push_back(mk(16'h0008, '0, '0, 4'd3, 0, 0, 4'd0, 16'h0000, 0, 0, 16'h0300, 1, 4'd3));
    tbl.push_back(mk(16'h0000, '0, '0, 4'd3, 0, 0, 4'd0, 16'h0000, 0, 0, 16'h0400, 0, 4'd3));
    // fcw[0]=0xFF00, two accumulations wrap to 0xFE00
    tbl.push_back(mk(16'h0000, '0, '0, 4'd0, 1, 0, 4'd0, 16'hFF00, 0, 0, 16'h0000, 0, 4'd0));
    tbl.push_back(mk(16'h0001, '0, '0, 4'd0, 0, 0, 4'd0, 16'h0000, 0, 0, 16'h0000, 1, 4'd0));
    tbl.push_back(mk(16'h0001, '0, '0, 4'd0, 0, 0, 4'd0, 16'h0000, 0, 0, 16'hFF00, 1, 4'd0));
    tbl.push_back(mk(16'h0000, '0, '0, 4'd0, 0, 0, 4'd0, 16'h0000, 0, 0, 16'hFE00, 0, 4'd0));
    // two qubits accumulate together
    tbl.push_back(mk(16'h0009, '0, '0, 4'd0, 0, 0, 4'd0, 16'h0000, 0, 0, 16'hFE00, 1, 4'd0));
    tbl.push_back(mk(16'h0000, '0, '0, 4'd3, 0, 0, 4'd0, 16'h0000, 0, 0, 16'h0500, 0, 4'd3));
    tbl.push_back(mk(16'h0000, '0, '0, 4'd0, 0, 0, 4'd0, 16'h0000, 0, 0, 16'hFD00, 0, 4'd0));
    // fcw[2] rewritten mid-accumulation: old step that cycle, new step after
    tbl.push_back(mk(16'h0000, '0, '0, 4'd2, 1, 0, 4'd2, 16'h0008, 0, 0, 16'h0000, 0, 4'd2));
    tbl.push_back(mk(16'h0004, '0, '0, 4'd2, 0, 0, 4'd0, 16'h0000, 0, 0, 16'h0000, 1, 4'd2));
    tbl.push_back(mk(16'h0004, '0, '0, 4'd2, 1, 0, 4'd2, 16'h0010, 0, 0, 16'h0008, 1, 4'd2));
    tbl.push_back(mk(16'h0004, '0, '0, 4'd2, 0, 0, 4'd0, 16'h0000, 0, 0, 16'h0010, 1, 4'd2));
    tbl.push_back(mk(16'h0000, '0, '0, 4'd2, 0, 0, 4'd0, 16'h0000, 0, 0, 16'h0020, 0, 4'd2));

    id = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], id);
      id++;
    end

    // z-correction on qubit 5: zstep=0x40, accumulate 3 cycles then hold
    apply(mk('0, '0, '0, 4'd5, 1, 1, 4'd5, 16'h0040, 0, 0, 16'h0000, 0, 4'd5), id++);
    for (int k = 0; k < 3; k++) begin
      apply(mk('0, 16'hFFFF, '0, 4'd5, 0, 0, 4'd0, 16'h0000, 0, 0, PW'(k * 'h40), 0, 4'd5), id++);
    end
    for (int k = 0; k < 2; k++) begin
      apply(mk('0, 16'hFFFF, 16'h0020, 4'd5, 0, 0, 4'd0, 16'h0000, 0, 0, 16'h00C0, 0, 4'd5), id++);
    end
    apply(mk('0, '0, '0, 4'd5, 0, 0, 4'd0, 16'h0000, 0, 0, 16'h00C0, 0, 4'd5), id++);

    // phase_out combines acc and zcorr on qubit 3
    apply(mk('0, '0, '0, 4'd3, 1, 1, 4'd3, 16'h0003, 0, 0, 16'h0500, 0, 4'd3), id++);
    apply(mk(16'h0008, 16'h0008, '0, 4'd3, 0, 0, 4'd0, 16'h0000, 0, 0, 16'h0500, 1, 4'd3), id++);
    apply(mk('0, '0, '0, 4'd3, 0, 0, 4'd0, 16'h0000, 0, 0, 16'h0603, 0, 4'd3), id++);

    // clear wins over a coincident z-accumulate
    apply(mk('0, 16'hFFFF, '0, 4'd5, 0, 0, 4'd0, 16'h0000, 1, 0, 16'h00C0, 0, 4'd5), id++);
    apply(mk('0, '0, '0, 4'd5, 0, 0, 4'd0, 16'h0000, 0, 0, 16'h0000, 0, 4'd5), id++);
    apply(mk('0, '0, '0, 4'd3, 0, 0, 4'd0, 16'h0000, 0, 0, 16'h0600, 0, 4'd3), id++);

    // reset mid-accumulation clears outputs and all per-qubit state
    apply(mk(16'h0008, 16'hFFFF, '0, 4'd3, 1, 0, 4'd3, 16'h1234, 0, 1, 16'h0000, 0, 4'd0), id++);
    apply(mk('0, '0, '0, 4'd3, 0, 0, 4'd0, 16'h0000, 0, 0, 16'h0000, 0, 4'd3), id++);
    apply(mk(16'h0008, '0, '0, 4'd3, 0, 0, 4'd0, 16'h0000, 0, 0, 16'h0000, 1, 4'd3), id++);
    apply(mk('0, '0, '0, 4'd3, 0, 0, 4'd0, 16'h0000, 0, 0, 16'h0000, 0, 4'd3), id++);
    apply(mk('0, '0, '0, 4'd0, 0, 0, 4'd0, 16'h0000, 0, 0, 16'h0000, 0, 4'd0), id++);

    // drain the last expectation
    @(negedge clk);
    check_out();
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
